// File: rtl/uart_tx.sv
// 8N1 UART transmitter; tx falls one clkx16 edge after a byte is accepted.
// One-byte holding buffer: ready drops while it is full or enable is low.
module uart_tx #(
  parameter logic parity_en  = 1'b0,
  parameter logic parity_odd = 1'b0,
  parameter int   stop_bits  = 1
) (
  input  logic       clkx16,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       tx,
  output logic       ready,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] buf_q, buf_d;
  logic       buf_full_q, buf_full_d;
  logic       tx_q, tx_d;

  logic accept;
  logic bit_end;
  logic last_stop;

  assign ready     = enable && !buf_full_q;
  assign busy      = (state_q != IDLE) || buf_full_q;
  assign tx        = tx_q;
  assign accept    = load && ready;
  assign bit_end   = (tick_q == 4'd15);
  // stop_q marks that the first of two stop bits has already gone out
  assign last_stop = (stop_bits == 1) || stop_q;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_d       = tx_q;
    if (enable) begin
      tick_d = tick_q + 4'd1;
      if (accept) begin
        buf_d      = data_in;
        buf_full_d = 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          tick_d = 4'd0;
          if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_d = DATA;
            idx_d   = 3'd0;
            tx_d    = shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              if (parity_en) begin
                state_d = PARITY;
                tx_d    = (^shift_q) ^ parity_odd;
              end else begin
                state_d = STOP;
                stop_d  = 1'b0;
                tx_d    = 1'b1;
              end
            end else begin
              idx_d = idx_q + 3'd1;
              tx_d  = shift_q[idx_d];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_d = 1'b1;
            end else if (buf_full_q) begin
              // back-to-back: next start bit follows the last stop tick directly
              shift_d    = buf_q;
              buf_full_d = 1'b0;
              state_d    = START;
              tick_d     = 4'd0;
              tx_d       = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clkx16) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= 4'd0;
      idx_q      <= 3'd0;
      stop_q     <= 1'b0;
      shift_q    <= 8'd0;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations, queued expected frames checked by line monitors.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] load_w = 4'b0000;
  logic [3:0] tx_w, ready_w, busy_w;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_start = 0;

  typedef struct {
    int          inst;
    logic [11:0] bits;      // frame bits, start bit in bit 0
    int          nbits;
    int          clks;      // clocks from start-bit edge to frame end
    logic        end_tx;    // line level at the first clock after the frame
    logic        end_busy;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx u_def (.clkx16(clk), .reset(rst), .enable(enable), .data_in(data_in),
                 .load(load_w[0]), .tx(tx_w[0]), .ready(ready_w[0]), .busy(busy_w[0]));
  uart_tx #(.parity_en(1'b1), .parity_odd(1'b0)) u_even
                (.clkx16(clk), .reset(rst), .enable(enable), .data_in(data_in),
                 .load(load_w[1]), .tx(tx_w[1]), .ready(ready_w[1]), .busy(busy_w[1]));
  uart_tx #(.parity_en(1'b1), .parity_odd(1'b1)) u_odd
                (.clkx16(clk), .reset(rst), .enable(enable), .data_in(data_in),
                 .load(load_w[2]), .tx(tx_w[2]), .ready(ready_w[2]), .busy(busy_w[2]));
  uart_tx #(.stop_bits(2)) u_stop2
                (.clkx16(clk), .reset(rst), .enable(enable), .data_in(data_in),
                 .load(load_w[3]), .tx(tx_w[3]), .ready(ready_w[3]), .busy(busy_w[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic monitor(input int i);
    exp_t e;
    logic prev, bad, badv, want_start;
    logic in_frame;
    int slot, tick, wall;
    prev = 1'b1; in_frame = 1'b0; bad = 1'b0; badv = 1'b0;
    slot = 0; tick = 0; wall = 0;
    e = '{inst: 0, bits: 12'd0, nbits: 0, clks: 0, end_tx: 1'b1, end_busy: 1'b0};
    forever begin
      @(posedge clk); #1;
      want_start = 1'b0;
      if (rst) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        want_start = prev && !tx_w[i];
      end else begin
        wall++;
        if (enable) begin
          tick++;
          if (tick == 16) begin
            tick = 0;
            vectors++;
            if (bad) begin
              miscompares++;
              $display("FAIL bit_slot inst%0d slot%0d: got %0b want %0b", i, slot, badv, e.bits[slot]);
            end
            bad = 1'b0;
            slot++;
          end
        end
        if (slot == e.nbits) begin
          vectors++;
          if (wall - 1 != e.clks) begin
            miscompares++;
            $display("FAIL frame_len inst%0d: got %0d want %0d", i, wall - 1, e.clks);
          end
          vectors++;
          if (tx_w[i] !== e.end_tx) begin
            miscompares++;
            $display("FAIL end_tx inst%0d: got %0b want %0b", i, tx_w[i], e.end_tx);
          end
          vectors++;
          if (busy_w[i] !== e.end_busy) begin
            miscompares++;
            $display("FAIL end_busy inst%0d: got %0b want %0b", i, busy_w[i], e.end_busy);
          end
          in_frame = 1'b0;
          want_start = !tx_w[i];
        end else if (tx_w[i] !== e.bits[slot] && !bad) begin
          bad = 1'b1;
          badv = tx_w[i];
        end
      end
      if (want_start) begin
        if (q.size() == 0 || q[0].inst != i) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame inst%0d: got start bit want idle line", i);
        end else begin
          e = q.pop_front();
          in_frame = 1'b1;
          slot = 0; tick = 0; wall = 1;
          bad = (tx_w[i] !== e.bits[0]);
          badv = tx_w[i];
        end
      end
      prev = rst ? 1'b1 : tx_w[i];
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic from_idle,
                      input logic [11:0] bits, input int nbits, input int clks,
                      input logic end_tx, input logic end_busy);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ready_w[i]) begin seen = 1'b1; break; end
    end
    check("ready_wait", {31'd0, seen}, 32'd1);
    q.push_back('{inst: i, bits: bits, nbits: nbits, clks: clks, end_tx: end_tx, end_busy: end_busy});
    data_in = d;
    load_w[i] = 1'b1;
    @(negedge clk);
    load_w[i] = 1'b0;
    check("ready_after_accept", {31'd0, ready_w[i]}, 32'd0);
    check("busy_after_accept", {31'd0, busy_w[i]}, 32'd1);
    if (from_idle) begin
      check("tx_before_start", {31'd0, tx_w[i]}, 32'd1);
      @(negedge clk);
      last_start = cyc;
      check("tx_start_latency", {31'd0, tx_w[i]}, 32'd0);
      check("ready_return", {31'd0, ready_w[i]}, 32'd1);
    end
  endtask

  task automatic wait_idle(output int span);
    logic done;
    done = 1'b0;
    span = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (busy_w == 4'b0000 && q.size() == 0) begin done = 1'b1; break; end
    end
    span = cyc - last_start;
    check("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int span;
    logic tx_held;
    logic quiet;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none

    // reset with enable low, then high
    repeat (2) @(negedge clk);
    check("reset_tx", {28'd0, tx_w}, 32'hF);
    check("reset_busy", {28'd0, busy_w}, 32'h0);
    check("reset_ready_en0", {28'd0, ready_w}, 32'h0);
    enable = 1'b1;
    @(negedge clk);
    check("reset_ready_en1", {28'd0, ready_w}, 32'hF);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single 0xA5 frame, default format
    send(0, 8'hA5, 1'b1, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 160, 1'b1, 1'b0);
    wait_idle(span);
    check("busy_span_a5", span, 32'd160);

    // back-to-back 0x55 then 0x0F
    send(0, 8'h55, 1'b1, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 160, 1'b0, 1'b1);
    send(0, 8'h0F, 1'b0, {2'b00, 1'b1, 8'h0F, 1'b0}, 10, 160, 1'b1, 1'b0);
    wait_idle(span);
    check("busy_span_b2b", span, 32'd320);

    // parity even (bit 1) and odd (bit 0) on 0x07
    send(1, 8'h07, 1'b1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 176, 1'b1, 1'b0);
    wait_idle(span);
    check("busy_span_even", span, 32'd176);
    send(2, 8'h07, 1'b1, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 176, 1'b1, 1'b0);
    wait_idle(span);
    check("busy_span_odd", span, 32'd176);

    // two stop bits on 0xFF
    send(3, 8'hFF, 1'b1, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 176, 1'b1, 1'b0);
    wait_idle(span);
    check("busy_span_stop2", span, 32'd176);

    // enable low for 40 clocks inside data bit 3, with an ignored load pulse
    send(0, 8'h3C, 1'b1, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 200, 1'b1, 1'b0);
    repeat (68) @(negedge clk);
    enable = 1'b0;
    tx_held = tx_w[0];
    repeat (10) @(negedge clk);
    check("ready_while_disabled", {28'd0, ready_w}, 32'h0);
    data_in = 8'hEE;
    load_w[0] = 1'b1;
    @(negedge clk);
    load_w[0] = 1'b0;
    repeat (29) @(negedge clk);
    check("tx_hold_disabled", {31'd0, tx_w[0]}, {31'd0, tx_held});
    enable = 1'b1;
    wait_idle(span);
    check("busy_span_stall", span, 32'd200);
    repeat (200) @(negedge clk);

    // reset during data bit 5 with a second byte buffered
    send(0, 8'h96, 1'b1, {2'b00, 1'b1, 8'h96, 1'b0}, 10, 160, 1'b1, 1'b0);
    send(0, 8'h69, 1'b0, {2'b00, 1'b1, 8'h69, 1'b0}, 10, 160, 1'b1, 1'b0);
    repeat (98) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check("midreset_tx", {31'd0, tx_w[0]}, 32'd1);
    check("midreset_busy", {31'd0, busy_w[0]}, 32'd0);
    check("midreset_ready", {31'd0, ready_w[0]}, 32'd1);
    quiet = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) quiet = 1'b0;
    end
    check("no_frame_after_reset", {31'd0, quiet}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
